// File: rtl/counter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package    : counter_pkg
// Description: Mode and direction encodings shared by the up/down counter.
// Revision   : 1.0
// ============================================================================
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updn_next.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : updn_next
// Description: Next-value and terminal-condition logic for a modulo up/down count.
// Revision   : 1.0
// ============================================================================
module updn_next
    import counter_pkg::*;
#(
    parameter int W       = 3,
    parameter int MODULUS = 8
) (
    input  logic [W-1:0] q,
    input  logic         inc,
    input  logic         sat,
    output logic [W-1:0] q_next,
    output logic         term
);

    localparam logic [W:0] C_MAX = (W+1)'(MODULUS - 1);

    logic [W:0] w_q_ext;
    logic [W:0] w_nxt;
    logic       w_unused;

    // One guard bit keeps the increment from silently wrapping at 2**W;
    // the selected value is always <= MODULUS-1, so the guard bit ends up 0.
    always_comb begin
        w_q_ext = {1'b0, q};
        term    = (inc == DIR_UP) ? (w_q_ext == C_MAX) : (w_q_ext == '0);
        w_nxt   = w_q_ext;
        if (!term) begin
            w_nxt = (inc == DIR_UP) ? (w_q_ext + (W+1)'(1)) : (w_q_ext - (W+1)'(1));
        end else if (sat == MODE_SAT) begin
            w_nxt = w_q_ext;
        end else begin
            w_nxt = (inc == DIR_UP) ? '0 : C_MAX;
        end
    end

    assign q_next   = w_nxt[W-1:0];
    assign w_unused = w_nxt[W];

endmodule : updn_next
`default_nettype wire

// File: rtl/updn_counter_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : updn_counter_param
// Description: Parametrised cascadable up/down counter with load, saturate
//              mode and sticky overflow flag.
// Revision   : 1.0
// ============================================================================
module updn_counter_param
    import counter_pkg::*;
#(
    parameter int W       = 3,
    parameter int MODULUS = 8,
    parameter int SET_VAL = 0
) (
    input  logic         clk,
    input  logic         set,
    input  logic         count,
    input  logic         inc,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         sat,
    input  logic         clr_ovf,
    output logic [W-1:0] q,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam logic [W:0]   C_MOD = (W+1)'(MODULUS);
    localparam logic [W-1:0] C_MAX = W'(MODULUS - 1);
    localparam logic [W-1:0] C_SET = W'(SET_VAL);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         ovf_q;
    logic         ovf_d;
    logic [W-1:0] w_q_next;
    logic         w_term;
    logic [W-1:0] w_ld_val;
    logic         w_ovf_evt;

    updn_next #(
        .W       (W),
        .MODULUS (MODULUS)
    ) u_next (
        .q      (q_q),
        .inc    (inc),
        .sat    (sat),
        .q_next (w_q_next),
        .term   (w_term)
    );

    // Out-of-range load data clamps to the top of the count range.
    always_comb begin
        w_ld_val  = ({1'b0, d} < C_MOD) ? d : C_MAX;
        w_ovf_evt = count & w_term & ~ld;
        ovf_d     = w_ovf_evt | (ovf_q & ~clr_ovf);
        q_d       = q_q;
        if (ld) begin
            q_d = w_ld_val;
        end else if (count) begin
            q_d = w_q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (set) begin
            q_q   <= C_SET;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q    = q_q;
    assign ovf  = ovf_q;
    assign zero = (q_q == '0);
    assign cout = count & w_term & ~ld & ~set;

endmodule : updn_counter_param
`default_nettype wire

// File: tb/tb_updn_counter_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_updn_counter_param
// Description: Directed scoreboard bench for updn_counter_param.
// Revision   : 1.0
// ============================================================================
module tb_updn_counter_param;

    typedef struct packed {
        logic       set;
        logic       count;
        logic       inc;
        logic       ld;
        logic [3:0] d;
        logic       sat;
        logic       clr;
    } in_t;

    typedef struct {
        int unsigned cyc;
        int          id;
        logic [7:0]  q;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          lo_pulses = 0;
    logic        casc_on = 1'b0;
    exp_t        sb[$];

    in_t in_a, in_b, in_c;

    logic [2:0] a_q;
    logic       a_cout, a_ovf, a_zero;
    logic [3:0] b_q;
    logic       b_cout, b_ovf, b_zero;
    logic [3:0] lo_q, hi_q;
    logic       lo_cout, lo_ovf, lo_zero, hi_cout, hi_ovf, hi_zero;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    updn_counter_param #(.W(3), .MODULUS(8), .SET_VAL(0)) u_a (
        .clk(clk), .set(in_a.set), .count(in_a.count), .inc(in_a.inc), .ld(in_a.ld),
        .d(in_a.d[2:0]), .sat(in_a.sat), .clr_ovf(in_a.clr),
        .q(a_q), .cout(a_cout), .ovf(a_ovf), .zero(a_zero));

    updn_counter_param #(.W(4), .MODULUS(10), .SET_VAL(2)) u_b (
        .clk(clk), .set(in_b.set), .count(in_b.count), .inc(in_b.inc), .ld(in_b.ld),
        .d(in_b.d), .sat(in_b.sat), .clr_ovf(in_b.clr),
        .q(b_q), .cout(b_cout), .ovf(b_ovf), .zero(b_zero));

    updn_counter_param #(.W(4), .MODULUS(10), .SET_VAL(0)) u_lo (
        .clk(clk), .set(in_c.set), .count(in_c.count), .inc(in_c.inc), .ld(in_c.ld),
        .d(in_c.d), .sat(in_c.sat), .clr_ovf(in_c.clr),
        .q(lo_q), .cout(lo_cout), .ovf(lo_ovf), .zero(lo_zero));

    updn_counter_param #(.W(4), .MODULUS(10), .SET_VAL(0)) u_hi (
        .clk(clk), .set(in_c.set), .count(lo_cout), .inc(in_c.inc), .ld(in_c.ld),
        .d(in_c.d), .sat(in_c.sat), .clr_ovf(in_c.clr),
        .q(hi_q), .cout(hi_cout), .ovf(hi_ovf), .zero(hi_zero));

    function automatic in_t mk(input logic s, c, i, l, input logic [3:0] dd,
                               input logic st, cl);
        in_t x;
        x.set = s; x.count = c; x.inc = i; x.ld = l; x.d = dd; x.sat = st; x.clr = cl;
        return x;
    endfunction

    // Apply inputs just after an edge; expectation describes q/ovf produced by
    // that edge and cout for the freshly applied inputs.
    task automatic step(input int id, input in_t x, input logic [7:0] eq,
                        input logic ecout, input logic eovf);
        exp_t e;
        @(posedge clk);
        #2;
        case (id)
            0:       in_a = x;
            1:       in_b = x;
            default: in_c = x;
        endcase
        e.cyc = cyc; e.id = id; e.q = eq; e.cout = ecout; e.ovf = eovf;
        sb.push_back(e);
    endtask

    task automatic chk(input exp_t e);
        logic [7:0] aq;
        logic       ac, ao, az, ez;
        case (e.id)
            0:       begin aq = {5'b0, a_q}; ac = a_cout; ao = a_ovf; az = a_zero; end
            1:       begin aq = {4'b0, b_q}; ac = b_cout; ao = b_ovf; az = b_zero; end
            default: begin aq = {hi_q, lo_q}; ac = lo_cout; ao = lo_ovf; az = lo_zero; end
        endcase
        ez = (e.id == 2) ? (e.q[3:0] == 4'd0) : (e.q == 8'd0);
        total++;
        if (aq !== e.q || ac !== e.cout || ao !== e.ovf || az !== ez) begin
            bad++;
            $display("FAIL dut%0d@cyc%0d: got q=%0h cout=%0b ovf=%0b zero=%0b, want q=%0h cout=%0b ovf=%0b zero=%0b",
                     e.id, e.cyc, aq, ac, ao, az, e.q, e.cout, e.ovf, ez);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) chk(sb.pop_front());
        if (casc_on && lo_cout === 1'b1) lo_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        in_a = mk(1, 0, 0, 0, 0, 0, 0);
        in_b = mk(1, 0, 0, 0, 0, 0, 0);
        in_c = mk(1, 0, 0, 0, 0, 0, 0);

        // u_a: reset then up-wrap (9 counts)
        step(0, mk(0,1,1,0,0,0,0), 0, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, mk(0,1,1,0,0,0,0), 8'(i), (i == 7), 0);
        step(0, mk(0,1,1,0,0,0,0), 0, 0, 1);
        step(0, mk(0,0,1,0,0,0,0), 1, 0, 1);
        // u_a: down-wrap, clear, event-beats-clear
        step(0, mk(1,0,0,0,0,0,0), 1, 0, 1);
        step(0, mk(0,1,0,0,0,0,0), 0, 1, 0);
        step(0, mk(0,1,0,0,0,0,0), 7, 0, 1);
        step(0, mk(0,1,0,0,0,0,0), 6, 0, 1);
        step(0, mk(0,0,0,0,0,0,1), 5, 0, 1);
        step(0, mk(0,0,0,0,0,0,0), 5, 0, 0);
        step(0, mk(0,0,0,1,7,0,0), 5, 0, 0);
        step(0, mk(0,1,1,0,0,0,1), 7, 1, 0);
        step(0, mk(0,0,0,0,0,0,0), 0, 0, 1);
        step(0, mk(0,1,0,0,0,0,0), 0, 1, 1);
        step(0, mk(0,0,0,0,0,0,0), 7, 0, 1);

        // u_b (MODULUS=10, SET_VAL=2): load 8 then saturate up
        step(1, mk(0,0,0,1,8,0,0), 2, 0, 0);
        step(1, mk(0,1,1,0,0,1,0), 8, 0, 0);
        step(1, mk(0,1,1,0,0,1,0), 9, 1, 0);
        step(1, mk(0,1,1,0,0,1,0), 9, 1, 1);
        step(1, mk(0,1,1,0,0,1,0), 9, 1, 1);
        step(1, mk(0,0,1,0,0,0,1), 9, 0, 1);
        // load beats count and clamps; set beats load
        step(1, mk(0,1,1,1,12,0,0), 9, 0, 0);
        step(1, mk(1,0,1,1,3,0,0), 9, 0, 0);
        step(1, mk(0,1,1,0,0,0,0), 2, 0, 0);
        step(1, mk(0,1,1,0,0,0,0), 3, 0, 0);
        step(1, mk(0,1,1,0,0,0,0), 4, 0, 0);
        // reset mid-count with count still high
        step(1, mk(1,1,1,0,0,0,0), 5, 0, 0);
        step(1, mk(0,1,1,0,0,0,0), 2, 0, 0);
        step(1, mk(0,0,1,1,10,0,0), 3, 0, 0);
        step(1, mk(0,0,1,1,0,0,0), 9, 0, 0);
        step(1, mk(0,1,0,0,0,1,0), 0, 1, 0);
        step(1, mk(0,0,0,0,0,1,0), 0, 0, 1);

        // cascade: BCD pair counting 25 steps
        casc_on = 1'b1;
        for (int i = 0; i <= 25; i++) begin
            step(2, mk(0, (i < 25), 1, 0, 0, 0, 0),
                 {4'(i / 10), 4'(i % 10)}, (i < 25) && (i % 10 == 9), (i >= 10));
        end
        @(negedge clk);
        @(negedge clk);
        casc_on = 1'b0;

        total++;
        if (lo_pulses != 2) begin
            bad++;
            $display("FAIL cascade_pulses: got %0d, want 2", lo_pulses);
        end
        total++;
        if (hi_ovf !== 1'b0) begin
            bad++;
            $display("FAIL cascade_hi_ovf: got %0b, want 0", hi_ovf);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_updn_counter_param
`default_nettype wire
